// File: rtl/pc_seq_if.sv
// pc_seq control/fetch bundle: the control unit drives the master side,
// the sequencer implements the slave side.
interface pc_seq_if #(
  parameter int AW = 10
);
  logic          stall;
  logic          s_inc;
  logic          s_rgj;
  logic [AW-1:0] imm_addr;
  logic [AW-1:0] reg_addr;
  logic          call;
  logic          ret;
  logic          iret;
  logic          irq;
  logic [AW-1:0] pc;
  logic [AW-1:0] tos;
  logic          full;
  logic          empty;
  logic          stack_err;
  logic          irq_ack;
  logic          in_isr;

  modport master (
    output stall, s_inc, s_rgj, imm_addr, reg_addr,
    output call, ret, iret, irq,
    input  pc, tos, full, empty, stack_err, irq_ack, in_isr
  );

  modport slave (
    input  stall, s_inc, s_rgj, imm_addr, reg_addr,
    input  call, ret, iret, irq,
    output pc, tos, full, empty, stack_err, irq_ack, in_isr
  );
endinterface

// File: rtl/pc_seq.sv
// Program sequencer: PC, next-address select, return stack, interrupt entry.
// Define PC_SEQ_IRQ_EN to enable the interrupt logic (irq/iret/irq_ack/in_isr).
module pc_seq #(
  parameter int            AW    = 10,
  parameter int            DEPTH = 8,
  parameter logic [AW-1:0] IVEC  = AW'('h3F0)
) (
  input logic     clk,
  input logic     reset,
  pc_seq_if.slave bus
);

  localparam int PW = $clog2(DEPTH) + 1;

  typedef enum logic {RUN, ISR} state_t;

  state_t        st_q, st_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] stk_q [DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic [PW-1:0] sp_m1;
  logic          err_q, err_d;
  logic          ack_q, ack_d;

  logic [AW-1:0] tgt;
  logic [AW-1:0] nxt;
  logic [AW-1:0] top;
  logic [AW-1:0] base;
  logic [AW-1:0] push_val;
  logic          is_full;
  logic          is_empty;
  logic          take;
  logic          do_push;
  logic          wr;

  logic act_pop;
  logic act_call;
  logic act_jmp;
  logic act_seq;

  assign tgt      = bus.s_rgj ? bus.reg_addr : bus.imm_addr;
  assign nxt      = pc_q + 1'b1;
  assign sp_m1    = sp_q - 1'b1;
  assign is_full  = (sp_q == PW'(DEPTH));
  assign is_empty = (sp_q == '0);
  assign top      = is_empty ? '0 : stk_q[sp_m1[PW-2:0]];

`ifdef PC_SEQ_IRQ_EN
  assign take = (st_q == RUN) && bus.irq && !bus.stall;
`else
  assign take = 1'b0;
`endif

  // one-hot view of the non-interrupt priority rows
  assign act_pop  = bus.ret | bus.iret;
  assign act_call = !act_pop && bus.call;
  assign act_jmp  = !act_pop && !bus.call && !bus.s_inc;
  assign act_seq  = !act_pop && !bus.call && bus.s_inc;

  always_comb begin
    base = nxt;
    unique case (1'b1)
      act_pop:  base = top;
      act_call: base = tgt;
      act_jmp:  base = tgt;
      act_seq:  base = nxt;
      default:  base = nxt;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    sp_d     = sp_q;
    err_d    = err_q;
    ack_d    = 1'b0;
    st_d     = st_q;
    push_val = nxt;
    do_push  = 1'b0;
    wr       = 1'b0;
    if (!bus.stall) begin
      if (take) begin
        // absorbed call/ret/iret: only its target survives, as the pushed PC
        push_val = base;
        do_push  = 1'b1;
        pc_d     = IVEC;
        st_d     = ISR;
        ack_d    = 1'b1;
      end else if (act_pop) begin
        if (is_empty) begin
          pc_d  = '0;
          err_d = 1'b1;
        end else begin
          pc_d = top;
          sp_d = sp_m1;
        end
        if (bus.iret && st_q == ISR)
          st_d = RUN;
      end else if (act_call) begin
        push_val = nxt;
        do_push  = 1'b1;
        pc_d     = tgt;
      end else begin
        pc_d = base;
      end
      if (do_push) begin
        if (is_full) begin
          err_d = 1'b1;
        end else begin
          wr   = 1'b1;
          sp_d = sp_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= RUN;
      pc_q  <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
      ack_q <= ack_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        stk_q[i] <= '0;
    end else if (wr) begin
      stk_q[sp_q[PW-2:0]] <= push_val;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.tos       = top;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.stack_err = err_q;
  assign bus.irq_ack   = ack_q;
  assign bus.in_isr    = (st_q == ISR);

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq (AW=10, DEPTH=8, IVEC=10'h3F0).
// Interrupt expectations follow PC_SEQ_IRQ_EN.
module tb_pc_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pc_seq_if #(.AW(10)) bif ();

  pc_seq #(
    .AW(10),
    .DEPTH(8),
    .IVEC(10'h3F0)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bif)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.stall    = 1'b0;
    bif.s_inc    = 1'b1;
    bif.s_rgj    = 1'b0;
    bif.imm_addr = '0;
    bif.reg_addr = '0;
    bif.call     = 1'b0;
    bif.ret      = 1'b0;
    bif.iret     = 1'b0;
    bif.irq      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic jump_to(input logic [9:0] a);
    bif.s_inc    = 1'b0;
    bif.imm_addr = a;
    step();
    bif.s_inc    = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if (bif.pc !== 10'd0) begin
      n_fail++; $display("FAIL reset_pc got %h want 000", bif.pc);
    end
    n_run++;
    if (bif.tos !== 10'd0) begin
      n_fail++; $display("FAIL reset_tos got %h want 000", bif.tos);
    end
    n_run++;
    if (bif.empty !== 1'b1 || bif.full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got e=%b f=%b want e=1 f=0",
               bif.empty, bif.full);
    end
    n_run++;
    if (bif.stack_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got %b want 0", bif.stack_err);
    end
    n_run++;
    if (bif.irq_ack !== 1'b0 || bif.in_isr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq got ack=%b isr=%b want 0 0",
               bif.irq_ack, bif.in_isr);
    end
  endtask

  task automatic test_seq();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step();
      n_run++;
      if (bif.pc !== 10'(i)) begin
        n_fail++; $display("FAIL seq_pc got %h want %h", bif.pc, 10'(i));
      end
    end
    bif.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_run++;
      if (bif.pc !== 10'd5) begin
        n_fail++; $display("FAIL stall_pc got %h want 005", bif.pc);
      end
    end
    bif.stall = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    jump_to(10'h3FF);
    n_run++;
    if (bif.pc !== 10'h3FF) begin
      n_fail++; $display("FAIL jump_pc got %h want 3ff", bif.pc);
    end
    step();
    n_run++;
    if (bif.pc !== 10'h000 || bif.stack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap got pc=%h err=%b want 000 0",
               bif.pc, bif.stack_err);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    jump_to(10'd7);
    bif.call     = 1'b1;
    bif.imm_addr = 10'h040;
    step();
    bif.call = 1'b0;
    n_run++;
    if (bif.pc !== 10'h040 || bif.tos !== 10'd8 || bif.empty !== 1'b0) begin
      n_fail++;
      $display("FAIL call got pc=%h tos=%h e=%b want 040 008 0",
               bif.pc, bif.tos, bif.empty);
    end
    bif.ret = 1'b1;
    step();
    bif.ret = 1'b0;
    n_run++;
    if (bif.pc !== 10'd8 || bif.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ret got pc=%h e=%b want 008 1", bif.pc, bif.empty);
    end
  endtask

  task automatic test_reg_jump();
    do_reset();
    bif.s_inc    = 1'b0;
    bif.s_rgj    = 1'b1;
    bif.reg_addr = 10'h155;
    bif.imm_addr = 10'h0AA;
    step();
    idle();
    n_run++;
    if (bif.pc !== 10'h155) begin
      n_fail++; $display("FAIL reg_jump got %h want 155", bif.pc);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    jump_to(10'h010);
    bif.call = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bif.imm_addr = 10'h020 + 10'(i);
      step();
      if (i == 7) begin
        n_run++;
        if (bif.full !== 1'b1 || bif.stack_err !== 1'b0) begin
          n_fail++;
          $display("FAIL full8 got f=%b err=%b want 1 0",
                   bif.full, bif.stack_err);
        end
      end
    end
    bif.call = 1'b0;
    n_run++;
    if (bif.pc !== 10'h028 || bif.stack_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf got pc=%h err=%b want 028 1", bif.pc, bif.stack_err);
    end
    n_run++;
    if (bif.tos !== 10'h027 || bif.full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_tos got tos=%h f=%b want 027 1", bif.tos, bif.full);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step();
    step();
    bif.ret = 1'b1;
    step();
    bif.ret = 1'b0;
    n_run++;
    if (bif.pc !== 10'd0 || bif.stack_err !== 1'b1 || bif.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL udf got pc=%h err=%b e=%b want 000 1 1",
               bif.pc, bif.stack_err, bif.empty);
    end
    step();
    n_run++;
    if (bif.pc !== 10'd1 || bif.stack_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got pc=%h err=%b want 001 1",
               bif.pc, bif.stack_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    jump_to(10'h030);
    bif.call     = 1'b1;
    bif.imm_addr = 10'h050;
    step();
    bif.imm_addr = 10'h060;
    step();
    bif.call = 1'b0;
    n_run++;
    if (bif.pc !== 10'h060 || bif.tos !== 10'h051) begin
      n_fail++;
      $display("FAIL b2b_call got pc=%h tos=%h want 060 051", bif.pc, bif.tos);
    end
    bif.ret = 1'b1;
    step();
    n_run++;
    if (bif.pc !== 10'h051 || bif.tos !== 10'h031) begin
      n_fail++;
      $display("FAIL b2b_ret1 got pc=%h tos=%h want 051 031", bif.pc, bif.tos);
    end
    step();
    bif.ret = 1'b0;
    n_run++;
    if (bif.pc !== 10'h031 || bif.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ret2 got pc=%h e=%b want 031 1", bif.pc, bif.empty);
    end
  endtask

  task automatic test_irq();
    do_reset();
    jump_to(10'd20);
    bif.irq = 1'b1;
    step();
`ifdef PC_SEQ_IRQ_EN
    n_run++;
    if (bif.pc !== 10'h3F0 || bif.tos !== 10'd21) begin
      n_fail++;
      $display("FAIL irq_entry got pc=%h tos=%h want 3f0 015", bif.pc, bif.tos);
    end
    n_run++;
    if (bif.irq_ack !== 1'b1 || bif.in_isr !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_ack got ack=%b isr=%b want 1 1",
               bif.irq_ack, bif.in_isr);
    end
    step();
    n_run++;
    if (bif.pc !== 10'h3F1 || bif.irq_ack !== 1'b0 || bif.in_isr !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_nonest got pc=%h ack=%b isr=%b want 3f1 0 1",
               bif.pc, bif.irq_ack, bif.in_isr);
    end
    bif.irq  = 1'b0;
    bif.iret = 1'b1;
    step();
    bif.iret = 1'b0;
    n_run++;
    if (bif.pc !== 10'd21 || bif.in_isr !== 1'b0 || bif.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL iret got pc=%h isr=%b e=%b want 015 0 1",
               bif.pc, bif.in_isr, bif.empty);
    end
`else
    bif.irq = 1'b0;
    n_run++;
    if (bif.pc !== 10'd21 || bif.irq_ack !== 1'b0 || bif.in_isr !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_off got pc=%h ack=%b isr=%b want 015 0 0",
               bif.pc, bif.irq_ack, bif.in_isr);
    end
`endif
  endtask

  task automatic test_irq_call();
    do_reset();
    jump_to(10'd4);
    bif.irq      = 1'b1;
    bif.call     = 1'b1;
    bif.imm_addr = 10'h100;
    step();
    bif.irq  = 1'b0;
    bif.call = 1'b0;
`ifdef PC_SEQ_IRQ_EN
    n_run++;
    if (bif.pc !== 10'h3F0 || bif.tos !== 10'h100 || bif.empty !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_call got pc=%h tos=%h e=%b want 3f0 100 0",
               bif.pc, bif.tos, bif.empty);
    end
    bif.iret = 1'b1;
    step();
    bif.iret = 1'b0;
    n_run++;
    if (bif.pc !== 10'h100 || bif.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_call_iret got pc=%h e=%b want 100 1",
               bif.pc, bif.empty);
    end
`else
    n_run++;
    if (bif.pc !== 10'h100 || bif.tos !== 10'd5) begin
      n_fail++;
      $display("FAIL call_noirq got pc=%h tos=%h want 100 005",
               bif.pc, bif.tos);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    jump_to(10'h0F0);
    bif.call     = 1'b1;
    bif.imm_addr = 10'h200;
    step();
    bif.call  = 1'b0;
    bif.stall = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    n_run++;
    if (bif.pc !== 10'd0 || bif.empty !== 1'b1 || bif.tos !== 10'd0) begin
      n_fail++;
      $display("FAIL async_rst got pc=%h e=%b tos=%h want 000 1 000",
               bif.pc, bif.empty, bif.tos);
    end
    step();
    bif.stall = 1'b0;
    rst_n = 1'b1;
    step();
    n_run++;
    if (bif.pc !== 10'd1) begin
      n_fail++; $display("FAIL post_rst got pc=%h want 001", bif.pc);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_seq();
    test_wrap();
    test_call_ret();
    test_reg_jump();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_irq();
    test_irq_call();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program sequencer: the successor to the fixed 10-bit PC / incrementer / jump-mux path of the single-cycle datapath. It holds the PC, selects the next fetch address (sequential, immediate jump, register jump, call, return), and keeps a hardware return-address stack with full/empty detection. It also takes a level-sensitive interrupt with acknowledge and an in-service state. It sits between the control unit and the program memory address input.

## Interface
Parameters:
- AW, 10, PC/address width
- DEPTH, 8, return-stack entries (power of two, ≥2)
- IVEC, 10'h3F0, interrupt vector (AW bits)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and stack this cycle
- s_inc  in  1  1 = PC+1, 0 = jump
- s_rgj  in  1  jump source: 1 = reg_addr, 0 = imm_addr
- imm_addr  in  AW  immediate target
- reg_addr  in  AW  register target
- call  in  1  push PC+1, then jump
- ret  in  1  pop, PC ← popped value
- iret  in  1  return from interrupt
- irq  in  1  level interrupt request
- pc  out  AW  current fetch address
- tos  out  AW  top-of-stack value (0 when empty)
- full  out  1  stack holds DEPTH entries
- empty  out  1  stack holds 0 entries
- stack_err  out  1  sticky overflow/underflow flag
- irq_ack  out  1  one-cycle pulse on interrupt entry
- in_isr  out  1  interrupt being serviced

## Operation
- Reset (reset=0, asynchronous): pc=0, stack pointer=0, all stack entries=0, empty=1, full=0, stack_err=0, irq_ack=0, in_isr=0, state=RUN.
- Target: tgt = s_rgj ? reg_addr : imm_addr. Sequential address: nxt = pc+1, truncated to AW bits (all-ones wraps to 0).
- Per-edge priority, highest first:
  1. stall: nothing changes; irq_ack=0.
  2. Interrupt entry (state RUN, irq=1): push the address this cycle would otherwise load (computed from the lower-priority rows), pc←IVEC, state→ISR, irq_ack=1 next cycle. Any call/ret/iret in the same cycle is absorbed: its target is the pushed address, and its stack effect is discarded.
  3. iret: in ISR, pop, pc←popped value, state→RUN. In RUN, iret behaves as ret.
  4. ret: pop, pc←popped value.
  5. call: push nxt, pc←tgt.
  6. s_inc=0: pc←tgt.
  7. Otherwise: pc←nxt.
- irq is ignored while in ISR (no nesting). in_isr = (state==ISR).
- States: RUN → ISR on taken irq; ISR → RUN on iret. No other transitions except reset.
- Overflow (push while full): no write, pointer unchanged, stack_err←1. The PC change (jump or IVEC) still occurs.
- Underflow (pop while empty): pointer unchanged, pc←0, stack_err←1. On iret, the state still returns to RUN.
- stack_err clears only on reset.
- full/empty/tos are combinational from the pointer and stack array.

## Timing
- All state is registered on the rising edge of clk, except for asynchronous reset.
- One-cycle latency: inputs sampled at edge N determine pc after edge N.
- irq_ack is high for exactly the one cycle following the entry edge.
- Reset asserted mid-ISR or mid-stall returns everything to reset values immediately. The first fetch after release is address 0.
- Release of reset is assumed synchronous to clk by the system. The first edge with reset=1 performs a normal update.

## Configuration
- PC_SEQ_IRQ_EN defined: interrupt logic, ISR state, irq_ack and in_isr are present as described.
- Not defined: irq is ignored, irq_ack=0, in_isr=0, and iret behaves exactly as ret. Stack and all other behaviour are unchanged.

## Test plan
- Reset then 5 edges with s_inc=1: pc = 0,1,2,3,4,5. Hold stall=1 for 2 edges: pc stays at 5.
- AW=10, pc=10'h3FF, s_inc=1: pc→0, no error.
- call imm_addr=10'h040 at pc=7, then ret: pc=10'h040, tos=8, empty=0; after ret, pc=8, empty=1.
- DEPTH=8: 9 consecutive calls → full=1 after the 8th call; 9th call sets stack_err=1, pc=target, tos=the 8th pushed value. ret on an empty stack → pc=0, stack_err=1.
- PC_SEQ_IRQ_EN, pc=20, s_inc=1, irq=1: pc=10'h3F0, tos=21, irq_ack=1 for one cycle, in_isr=1. irq held high is ignored. iret → pc=21, in_isr=0.
- irq and call (tgt=10'h100) in the same cycle at pc=4 with PC_SEQ_IRQ_EN: pc=10'h3F0, stack depth 1, tos=10'h100. iret → pc=10'h100, stack empty. Without PC_SEQ_IRQ_EN: pc=10'h100, tos=5.
